// File: rtl/baud_nco.sv
// rtl/baud_nco.sv - fractional phase-accumulator baud-rate NCO with oversample strobe
// Increment updates are staged and only take effect at a baud boundary, sync or idle edge.
module baud_nco #(
  parameter int ACC_WIDTH   = 32,
  parameter int OVERSAMPLE  = 16,
  parameter int DEFAULT_INC = 6597070,
  parameter int OS_W        = $clog2(OVERSAMPLE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 sync,
  input  logic                 inc_load,
  input  logic [ACC_WIDTH-1:0] inc_in,
  output logic                 tick_os,
  output logic                 tick,
  output logic [OS_W-1:0]      os_phase,
  output logic                 inc_pending,
  output logic                 inc_err
);

  localparam logic [ACC_WIDTH-1:0] DEF_INC = ACC_WIDTH'(DEFAULT_INC);
  localparam logic [OS_W-1:0]      OS_LAST = OS_W'(OVERSAMPLE - 1);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] inc_active;
  logic [ACC_WIDTH-1:0] inc_pend_val;
  logic [ACC_WIDTH:0]   sum;
  logic                 carry;
  logic                 at_last;
  logic                 boundary;
  logic                 load_ok;

  always_comb begin
    sum      = {1'b0, acc} + {1'b0, inc_active};
    carry    = sum[ACC_WIDTH];
    at_last  = (os_phase == OS_LAST);
    // Idle and sync edges count as boundaries, so a new rate can never split a baud period.
    boundary = sync | ~en | (carry & at_last);
    load_ok  = inc_load & (inc_in != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc          <= '0;
      os_phase     <= '0;
      inc_active   <= DEF_INC;
      inc_pend_val <= '0;
      inc_pending  <= 1'b0;
      tick_os      <= 1'b0;
      tick         <= 1'b0;
      inc_err      <= 1'b0;
    end else begin
      inc_err <= inc_load & (inc_in == '0);

      if (sync) begin
        acc      <= '0;
        os_phase <= '0;
        tick_os  <= 1'b0;
        tick     <= 1'b0;
      end else if (en) begin
        acc     <= sum[ACC_WIDTH-1:0];
        tick_os <= carry;
        tick    <= carry & at_last;
        if (carry) begin
          os_phase <= at_last ? '0 : os_phase + 1'b1;
        end
      end else begin
        tick_os <= 1'b0;
        tick    <= 1'b0;
      end

      if (load_ok && boundary) begin
        inc_active  <= inc_in;
        inc_pending <= 1'b0;
      end else if (load_ok) begin
        inc_pend_val <= inc_in;
        inc_pending  <= 1'b1;
      end else if (boundary && inc_pending) begin
        inc_active  <= inc_pend_val;
        inc_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_baud_nco.sv
// tb/tb_baud_nco.sv - self-checking bench for baud_nco (W=8, OVERSAMPLE=4, DEFAULT_INC=64)
// A rate-level model predicts every strobe; directed phases pin the model with literal values.
module tb_baud_nco;
  localparam int W   = 8;
  localparam int OS  = 4;
  localparam int DEF = 64;
  localparam int OSW = $clog2(OS);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic           sync = 1'b0;
  logic           inc_load = 1'b0;
  logic [W-1:0]   inc_in = '0;
  logic           tick_os, tick, inc_pending, inc_err;
  logic [OSW-1:0] os_phase;

  int n_chk = 0;
  int n_fail = 0;

  baud_nco #(.ACC_WIDTH(W), .OVERSAMPLE(OS), .DEFAULT_INC(DEF)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .inc_load(inc_load),
    .inc_in(inc_in), .tick_os(tick_os), .tick(tick), .os_phase(os_phase),
    .inc_pending(inc_pending), .inc_err(inc_err)
  );

  always #5 clk = ~clk;

  // Model: phase as an integer modulo 2^W, strobe count modulo OS, staged rate.
  int m_acc, m_inc, m_pv, m_cnt;
  bit m_pend, e_os, e_tick, e_err, m_valid = 0;

  always @(posedge clk) begin
    bit valid, bnd;
    int total;
    if (!rst_n) begin
      m_acc = 0; m_cnt = 0; m_inc = DEF; m_pv = 0; m_pend = 0;
      e_os = 0; e_tick = 0; e_err = 0; m_valid = 1;
    end else begin
      valid = inc_load && (inc_in != 0);
      e_err = inc_load && (inc_in == 0);
      if (sync) begin
        m_acc = 0; m_cnt = 0; e_os = 0; e_tick = 0; bnd = 1;
      end else if (en) begin
        total  = m_acc + m_inc;
        e_os   = (total >= (1 << W));
        m_acc  = total % (1 << W);
        e_tick = e_os && (m_cnt == OS - 1);
        if (e_os) m_cnt = (m_cnt + 1) % OS;
        bnd = e_tick;
      end else begin
        e_os = 0; e_tick = 0; bnd = 1;
      end
      if (valid && bnd) begin m_inc = inc_in; m_pend = 0; end
      else if (valid) begin m_pv = inc_in; m_pend = 1; end
      else if (bnd && m_pend) begin m_inc = m_pv; m_pend = 0; end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_tick_os", tick_os, e_os);
      chk("m_tick", tick, e_tick);
      chk("m_os_phase", os_phase, m_cnt);
      chk("m_inc_pending", inc_pending, m_pend);
      chk("m_inc_err", inc_err, e_err);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  // Edges until the next tick_os (or tick if want_tick), -1 when the bound expires.
  task automatic wait_os(input bit want_tick, input int lim, output int n);
    n = -1;
    for (int k = 1; k <= lim; k++) begin
      cyc();
      if (want_tick ? tick : tick_os) begin n = k; break; end
    end
  endtask

  initial begin
    int n, n_os, n_tk, last, min_gap;
    rst_n = 0;
    repeat (2) cyc();
    chk("rst_tick_os", tick_os, 0);
    chk("rst_os_phase", os_phase, 0);
    chk("rst_pending", inc_pending, 0);

    // Default rate 64: tick_os on edge 4, tick on edge 16.
    rst_n = 1; en = 1;
    wait_os(0, 10, n);  chk("first_os_edge", n, 4);
    chk("first_os_phase", os_phase, 1);
    wait_os(1, 20, n);  chk("first_tick_edges_more", n, 12);
    chk("tick_phase_wrap", os_phase, 0);

    // Rate 96 from phase 0 via sync: 256 edges -> 96 tick_os, 24 tick.
    sync = 1; inc_load = 1; inc_in = 96; cyc(); sync = 0; inc_load = 0;
    n_os = 0; n_tk = 0; last = 0; min_gap = 1000;
    for (int k = 1; k <= 256; k++) begin
      cyc();
      if (tick_os) begin
        if (last != 0 && k - last < min_gap) min_gap = k - last;
        last = k; n_os++;
      end
      if (tick) n_tk++;
    end
    chk("rate96_tick_os", n_os, 96);
    chk("rate96_tick", n_tk, 24);
    chk("rate96_min_gap", min_gap, 2);

    // Staged load: 128 then 32 before the boundary; 32 wins.
    sync = 1; inc_load = 1; inc_in = 64; cyc(); sync = 0; inc_load = 0;
    repeat (6) cyc();
    inc_load = 1; inc_in = 128; cyc(); inc_load = 0;
    chk("pend_set", inc_pending, 1);
    inc_load = 1; inc_in = 0; cyc(); inc_load = 0;
    chk("err_pulse", inc_err, 1);
    chk("err_keeps_pending", inc_pending, 1);
    chk("err_os_spacing4", tick_os, 1);
    cyc();
    chk("err_one_cycle", inc_err, 0);
    inc_load = 1; inc_in = 32; cyc(); inc_load = 0;
    wait_os(1, 20, n);  chk("pend_boundary_edge", n, 6);
    chk("pend_cleared", inc_pending, 0);
    wait_os(0, 20, n);  chk("latest_wins_gap", n, 8);
    wait_os(0, 20, n);  chk("latest_wins_gap2", n, 8);

    // Sync at os_phase=2, acc=192.
    sync = 1; inc_load = 1; inc_in = 64; cyc(); sync = 0; inc_load = 0;
    repeat (11) cyc();
    chk("pre_sync_phase", os_phase, 2);
    sync = 1; cyc(); sync = 0;
    chk("sync_phase", os_phase, 0);
    chk("sync_no_strobe", tick_os, 0);
    wait_os(0, 10, n);  chk("sync_first_os", n, 4);
    repeat (4) cyc();
    en = 0; sync = 1; cyc(); sync = 0; en = 1;
    chk("sync_en0_phase", os_phase, 0);
    wait_os(0, 10, n);  chk("sync_en0_first_os", n, 4);

    // Reset with a pending load discards it.
    repeat (2) cyc();
    inc_load = 1; inc_in = 200; cyc(); inc_load = 0;
    chk("rst_pend_set", inc_pending, 1);
    rst_n = 0; cyc(); rst_n = 1;
    chk("midrst_pending", inc_pending, 0);
    chk("midrst_tick_os", tick_os, 0);
    chk("midrst_phase", os_phase, 0);
    wait_os(0, 10, n);  chk("midrst_first_os", n, 4);
    wait_os(0, 10, n);  chk("midrst_gap", n, 4);

    // Random traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      en       = ($urandom % 8) != 0;
      sync     = ($urandom % 64) == 0;
      inc_load = ($urandom % 16) == 0;
      inc_in   = (($urandom % 5) == 0) ? '0 : W'($urandom_range(1, 255));
      rst_n    = ($urandom % 500) != 0;
      cyc();
    end
    en = 1; sync = 0; inc_load = 0; rst_n = 1;
    repeat (4) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
